// File: rtl/data_ram_hs_if.sv
// data_ram_hs_if: request/response handshake bundle between the load/store unit
// (master) and the data RAM (slave).
interface data_ram_hs_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_adr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_we, req_adr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_adr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_ram_hs.sv
// data_ram_hs: synchronous-read data RAM with valid/ready handshake, byte
// write enables, single-entry response stall and a whole-array clear engine.
// Optional macro RAM_BOUNDS_CHECK_EN: out-of-range requests raise the sticky
// err_flag and out-of-range reads return resp_err=1. Without it both are 0.
module data_ram_hs #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 65536
) (
  input  logic         clk,
  input  logic         rst_n,
  data_ram_hs_if.slave bus,
  input  logic         clr_start,
  output logic         busy,
  output logic         err_flag
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [0:0] {IDLE, CLEAR} stateT;

  stateT              stateReg, stateNext;
  logic [CNT_W-1:0]   cntReg, cntNext;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic               respValidReg;
  logic [DATA_W-1:0]  respRdataReg;
  logic               respErrReg;
  logic               respErrNext;

  logic               reqReady;
  logic               accept;
  logic               rdAccept;
  logic               wrAccept;
  logic               inRange;
  logic [IDX_W-1:0]   adrIdx;
  logic [IDX_W-1:0]   clrIdx;

  // Request side: clr_start steals the cycle, a held response blocks new reads.
  assign reqReady = (stateReg == IDLE) && !clr_start &&
                    (!respValidReg || bus.resp_ready);
  assign accept   = bus.req_valid && reqReady;
  assign rdAccept = accept && !bus.req_we;
  assign wrAccept = accept &&  bus.req_we;

  // Widened compare so DEPTH == 2^ADDR_W still fits.
  assign inRange = ({1'b0, bus.req_adr} < CNT_W'(DEPTH));
  assign adrIdx  = bus.req_adr[IDX_W-1:0];
  assign clrIdx  = cntReg[IDX_W-1:0];

  assign bus.req_ready  = reqReady;
  assign bus.resp_valid = respValidReg;
  assign bus.resp_rdata = respRdataReg;
  assign bus.resp_err   = respErrReg;
  assign busy           = (stateReg == CLEAR);

  // FSM state and clear counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= IDLE;
      cntReg   <= '0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
    end
  end

  // Next-state logic: one word cleared per cycle, exit after the last index.
  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    unique case (stateReg)
      IDLE: begin
        if (clr_start) begin
          stateNext = CLEAR;
          cntNext   = '0;
        end
      end
      CLEAR: begin
        if (cntReg == CNT_W'(DEPTH - 1)) begin
          stateNext = IDLE;
          cntNext   = '0;
        end else begin
          cntNext = cntReg + CNT_W'(1);
        end
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  // Memory array write port: clear engine or byte-masked store; no reset.
  always_ff @(posedge clk) begin
    if (stateReg == CLEAR) begin
      mem[clrIdx] <= '0;
    end else if (wrAccept && inRange) begin
      for (int b = 0; b < BE_W; b++) begin
        if (bus.req_be[b]) begin
          mem[adrIdx][b*8 +: 8] <= bus.req_wdata[b*8 +: 8];
        end
      end
    end
  end

`ifdef RAM_BOUNDS_CHECK_EN
  logic errFlagReg;

  assign respErrNext = !inRange;
  assign err_flag    = errFlagReg;

  // Sticky out-of-range flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errFlagReg <= 1'b0;
    end else if (accept && !inRange) begin
      errFlagReg <= 1'b1;
    end
  end
`else
  assign respErrNext = 1'b0;
  assign err_flag    = 1'b0;
`endif

  // Registered read port and response holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      respValidReg <= 1'b0;
      respRdataReg <= '0;
      respErrReg   <= 1'b0;
    end else if (rdAccept) begin
      respValidReg <= 1'b1;
      respRdataReg <= inRange ? mem[adrIdx] : '0;
      respErrReg   <= respErrNext;
    end else if (respValidReg && bus.resp_ready) begin
      respValidReg <= 1'b0;
    end
  end

endmodule
